epp_reg_slave: RTL

Parametrised EPP slave that terminates the host parallel-port protocol and exposes a bank of `NUM_REGS` 8-bit registers. Host address cycles load an internal address pointer. Host data cycles write a control register or read a status input. Strobes are synchronised into `CLK`, and the pointer optionally auto-increments for block transfers. It replaces the single address/data latch interface between the host link and the FPGA user logic.

---
 rtl/epp_pkg.sv | 18 +
 rtl/epp_sync.sv | 27 ++
 rtl/epp_reg_slave.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/epp_pkg.sv
// Shared definitions for the EPP register slave: bus widths and FSM states.
`timescale 1ns/1ps

package epp_pkg;

  localparam int EPP_DW = 8;
  localparam int EPP_AW = 8;

  typedef enum logic [2:0] {
    IDLE,
    AWR,
    ARD,
    DWR,
    DRD,
    HOLD
  } epp_state_e;

endpackage

// File: rtl/epp_sync.sv
// Multi-stage synchroniser for one asynchronous, active-low host strobe.
// Resets to 1 so that an idle bus looks inactive straight out of reset.
`timescale 1ns/1ps

module epp_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  // Shift the raw pin through the chain; the last stage is the clean copy
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= '1;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/epp_reg_slave.sv
// EPP host-port slave exposing a bank of 8-bit control registers and
// returning 8-bit status values. Address cycles load a pointer, data cycles
// write a control register or read a status input through a frozen holding
// register, and the pointer can auto-increment for block transfers.
`timescale 1ns/1ps

module epp_reg_slave
  import epp_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter int          SYNC_STAGES = 2,
  parameter bit          AUTO_INC    = 1'b1,
  parameter logic [7:0]  RST_VAL     = 8'h00
) (
  input  logic                  CLK,
  input  logic                  RST,
  inout  wire  [EPP_DW-1:0]     DB,
  input  logic                  nASTB,
  input  logic                  nDSTB,
  input  logic                  nWRITE,
  output logic                  WAIT,
  output logic [EPP_AW-1:0]     ADDR,
  output logic [8*NUM_REGS-1:0] REG_OUT,
  output logic [NUM_REGS-1:0]   REG_WR_STB,
  input  logic [8*NUM_REGS-1:0] REG_IN,
  output logic [NUM_REGS-1:0]   REG_RD_STB,
  output logic                  ERR
);

  logic s_astb;
  logic s_dstb;
  logic s_write;

  epp_state_e               state;
  logic                     wait_q;
  logic [EPP_AW-1:0]        addr_q;
  logic [8*NUM_REGS-1:0]    reg_q;
  logic [NUM_REGS-1:0]      wr_stb_q;
  logic [NUM_REGS-1:0]      rd_stb_q;
  logic                     err_q;
  logic [EPP_DW-1:0]        hold_q;
  logic                     drive_q;
  logic                     cyc_data_q;

  logic                     in_range;
  logic [EPP_DW-1:0]        rd_sel;

  epp_sync #(.STAGES(SYNC_STAGES)) u_sync_astb (
    .clk (CLK),
    .rst (RST),
    .d   (nASTB),
    .q   (s_astb)
  );

  epp_sync #(.STAGES(SYNC_STAGES)) u_sync_dstb (
    .clk (CLK),
    .rst (RST),
    .d   (nDSTB),
    .q   (s_dstb)
  );

  epp_sync #(.STAGES(SYNC_STAGES)) u_sync_write (
    .clk (CLK),
    .rst (RST),
    .d   (nWRITE),
    .q   (s_write)
  );

  assign in_range = ({1'b0, addr_q} < 9'(NUM_REGS));

  // Select the status byte addressed by the pointer; zero when out of range
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == 8'(i)) begin
        rd_sel = REG_IN[8*i +: 8];
      end
    end
  end

  // Protocol FSM with the pointer, register bank, strobes and read holding register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      wait_q     <= 1'b0;
      addr_q     <= '0;
      reg_q      <= {NUM_REGS{RST_VAL}};
      wr_stb_q   <= '0;
      rd_stb_q   <= '0;
      err_q      <= 1'b0;
      hold_q     <= '0;
      drive_q    <= 1'b0;
      cyc_data_q <= 1'b0;
    end else begin
      wr_stb_q <= '0;
      rd_stb_q <= '0;
      case (state)
        IDLE: begin
          if (!s_astb && !s_dstb) begin
            err_q      <= 1'b1;
            wait_q     <= 1'b1;
            cyc_data_q <= 1'b0;
            state      <= HOLD;
          end else if (!s_astb) begin
            cyc_data_q <= 1'b0;
            if (s_write) begin
              hold_q  <= addr_q;
              drive_q <= 1'b1;
              state   <= ARD;
            end else begin
              state   <= AWR;
            end
          end else if (!s_dstb) begin
            cyc_data_q <= 1'b1;
            if (s_write) begin
              hold_q  <= rd_sel;
              drive_q <= 1'b1;
              state   <= DRD;
            end else begin
              state   <= DWR;
            end
          end
        end
        AWR: begin
          addr_q <= DB;
          wait_q <= 1'b1;
          state  <= HOLD;
        end
        ARD: begin
          wait_q <= 1'b1;
          state  <= HOLD;
        end
        DWR: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (in_range && addr_q == 8'(i)) begin
              reg_q[8*i +: 8] <= DB;
              wr_stb_q[i]     <= 1'b1;
            end
          end
          wait_q <= 1'b1;
          state  <= HOLD;
        end
        DRD: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (in_range && addr_q == 8'(i)) begin
              rd_stb_q[i] <= 1'b1;
            end
          end
          wait_q <= 1'b1;
          state  <= HOLD;
        end
        HOLD: begin
          if (s_astb && s_dstb) begin
            wait_q  <= 1'b0;
            drive_q <= 1'b0;
            state   <= IDLE;
            if (cyc_data_q && AUTO_INC) begin
              addr_q <= addr_q + 8'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign DB         = drive_q ? hold_q : 8'bz;
  assign WAIT       = wait_q;
  assign ADDR       = addr_q;
  assign REG_OUT    = reg_q;
  assign REG_WR_STB = wr_stb_q;
  assign REG_RD_STB = rd_stb_q;
  assign ERR        = err_q;

endmodule
